sar_search_8: RTL and testbench

Successive-approximation search engine that drives the probe operand of an external `compare_8` 8-bit magnitude comparator and consumes its `QAGB`/`QASB`/`QAEB` flags. It recovers an unknown 8-bit value presented on the comparator's other operand. The search runs a bit-serial binary search from MSB to LSB and terminates early on an equality flag. It sits beside `compare_8` in the integration top: `Probe` drives `DataA`, the unknown drives `DataB`, and the three flags return here.

---
 rtl/sar_pkg.sv | 16 +
 rtl/compare_8.sv | 14 +
 rtl/sar_search_8.sv | 128 ++++++++++++
 tb/tb_sar_search_8.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search engine.
package sar_pkg;

    localparam int SAR_WIDTH  = 8;
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W      = $clog2(SETTLE_MAX + 1);
    localparam int IDX_W      = $clog2(SAR_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } sar_state_t;

endpackage

// File: rtl/compare_8.sv
// 8-bit magnitude comparator; lives in the integration top beside sar_search_8.
module compare_8 (
    input  logic [7:0] DataA,
    input  logic [7:0] DataB,
    output logic       QAGB,
    output logic       QASB,
    output logic       QAEB
);

    assign QAGB = (DataA > DataB);
    assign QASB = (DataA < DataB);
    assign QAEB = (DataA == DataB);

endmodule

// File: rtl/sar_search_8.sv
// Bit-serial binary search that recovers the unknown operand of an external
// magnitude comparator by steering its probe operand from MSB to LSB.
module sar_search_8
    import sar_pkg::*;
#(
    parameter int SETTLE = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Start,
    input  logic                 QAGB,
    input  logic                 QASB,
    input  logic                 QAEB,
    output logic [SAR_WIDTH-1:0] Probe,
    output logic [SAR_WIDTH-1:0] Result,
    output logic                 Done,
    output logic                 Busy,
    output logic                 Found,
    output logic                 Err
);

    localparam logic [CNT_W-1:0]     SETTLE_LD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0]     MSB_IDX   = IDX_W'(SAR_WIDTH - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
    localparam logic [SAR_WIDTH-1:0] MSB_ONLY  = {1'b1, {(SAR_WIDTH - 1){1'b0}}};

    if (SETTLE < 0 || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("sar_search_8: SETTLE out of range");
    end

    sar_state_t           state, state_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [SAR_WIDTH-1:0] probe_n, result_n, trial;
    logic                 found_n, err_n;
    logic                 flags_ok;

    assign flags_ok = $onehot({QAGB, QASB, QAEB});

    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        cnt_n     = cnt;
        probe_n   = Probe;
        result_n  = Result;
        found_n   = Found;
        err_n     = Err;
        trial     = Probe;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    probe_n   = MSB_ONLY;
                    bit_idx_n = MSB_IDX;
                    cnt_n     = SETTLE_LD;
                    found_n   = 1'b0;
                    err_n     = 1'b0;
                    result_n  = '0;
                    state_n   = (SETTLE > 0) ? WAIT : SAMPLE;
                end
            end
            WAIT: begin
                cnt_n = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                // Bad flag combinations take priority over any decision.
                if (!flags_ok) begin
                    err_n    = 1'b1;
                    result_n = '0;
                    state_n  = DONE;
                end else if (QAEB) begin
                    result_n = Probe;
                    found_n  = 1'b1;
                    state_n  = DONE;
                end else begin
                    if (QAGB) begin
                        trial[bit_idx] = 1'b0;
                    end
                    if (bit_idx == '0) begin
                        probe_n  = trial;
                        result_n = trial;
                        found_n  = 1'b0;
                        state_n  = DONE;
                    end else begin
                        trial[bit_idx - IDX_ONE] = 1'b1;
                        probe_n   = trial;
                        bit_idx_n = bit_idx - IDX_ONE;
                        cnt_n     = SETTLE_LD;
                        state_n   = (SETTLE > 0) ? WAIT : SAMPLE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            bit_idx <= MSB_IDX;
            cnt     <= '0;
            Probe   <= '0;
            Result  <= '0;
            Found   <= 1'b0;
            Err     <= 1'b0;
        end else begin
            state   <= state_n;
            bit_idx <= bit_idx_n;
            cnt     <= cnt_n;
            Probe   <= probe_n;
            Result  <= result_n;
            Found   <= found_n;
            Err     <= err_n;
        end
    end

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_sar_search_8.sv
// Scoreboard bench: two engines (SETTLE 0 and 2), each searching a real compare_8.
module tb_sar_search_8;

    typedef struct packed {
        logic [0:0]  unit;
        logic [7:0]  result;
        logic        found;
        logic        err;
        logic [3:0]  n;
        logic [63:0] trace;
        logic [7:0]  latency;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ovr;
    logic       start [2];
    logic [7:0] target [2];
    logic [7:0] probe [2];
    logic [7:0] result [2];
    logic       done [2];
    logic       busy [2];
    logic       found [2];
    logic       err [2];
    logic       cgb [2];
    logic       csb [2];
    logic       ceb [2];
    logic       fgb0, fsb0, feb0;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_busy [2];
    logic        prev_done [2];
    logic [7:0]  last_probe [2];
    logic [63:0] trace [2];
    int          tcnt [2];
    int          cycles [2];
    int          done_count [2] = '{0, 0};

    always #5 clk = ~clk;

    // Unit 0 flags can be forced into an illegal GB+SB combination.
    assign fgb0 = ovr | cgb[0];
    assign fsb0 = ovr | csb[0];
    assign feb0 = ~ovr & ceb[0];

    compare_8 u_cmp0 (.DataA(probe[0]), .DataB(target[0]),
                      .QAGB(cgb[0]), .QASB(csb[0]), .QAEB(ceb[0]));
    compare_8 u_cmp1 (.DataA(probe[1]), .DataB(target[1]),
                      .QAGB(cgb[1]), .QASB(csb[1]), .QAEB(ceb[1]));

    sar_search_8 #(.SETTLE(0)) dut0 (
        .CLK(clk), .RST(rst), .Start(start[0]),
        .QAGB(fgb0), .QASB(fsb0), .QAEB(feb0),
        .Probe(probe[0]), .Result(result[0]), .Done(done[0]),
        .Busy(busy[0]), .Found(found[0]), .Err(err[0])
    );

    sar_search_8 #(.SETTLE(2)) dut1 (
        .CLK(clk), .RST(rst), .Start(start[1]),
        .QAGB(cgb[1]), .QASB(csb[1]), .QAEB(ceb[1]),
        .Probe(probe[1]), .Result(result[1]), .Done(done[1]),
        .Busy(busy[1]), .Found(found[1]), .Err(err[1])
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: rebuilds the probe trace per search and pops the scoreboard on Done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                prev_busy[u] = 1'b0;
                prev_done[u] = 1'b0;
                tcnt[u]      = 0;
                cycles[u]    = 0;
                trace[u]     = '0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (prev_done[u]) begin
                    checkOutput("done_pulse_end", {62'd0, busy[u], done[u]}, 64'd0);
                end
                if (busy[u] && !prev_busy[u]) begin
                    tcnt[u]   = 0;
                    cycles[u] = 0;
                    trace[u]  = '0;
                    checkOutput("start_clears", {54'd0, result[u], found[u], err[u]}, 64'd0);
                end
                if (busy[u]) begin
                    cycles[u]++;
                    if (!done[u] && (!prev_busy[u] || probe[u] != last_probe[u])) begin
                        if (tcnt[u] < 8) begin
                            trace[u][63 - 8 * tcnt[u] -: 8] = probe[u];
                        end
                        tcnt[u]++;
                    end
                end
                if (done[u]) begin
                    done_count[u]++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done unit=%0d actual=1 expected=0", u);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("unit", 64'(u), 64'(e.unit));
                        checkOutput("result", 64'(result[u]), 64'(e.result));
                        checkOutput("found", 64'(found[u]), 64'(e.found));
                        checkOutput("err", 64'(err[u]), 64'(e.err));
                        checkOutput("decisions", 64'(tcnt[u]), 64'(e.n));
                        checkOutput("probe_trace", trace[u], e.trace);
                        checkOutput("latency", 64'(cycles[u] - 1), 64'(e.latency));
                    end
                end
                prev_busy[u]  = busy[u];
                prev_done[u]  = done[u];
                last_probe[u] = probe[u];
            end
        end
    end

    task automatic applyStimulus(input int u, input logic [7:0] tgt,
                                 input logic [7:0] res, input logic fnd, input logic er,
                                 input int n, input logic [63:0] tr, input int lat,
                                 input int mid_start);
        exp_t e;
        int   waited;
        e.unit    = 1'(u);
        e.result  = res;
        e.found   = fnd;
        e.err     = er;
        e.n       = 4'(n);
        e.trace   = tr;
        e.latency = 8'(lat);
        target[u] = tgt;
        sb.push_back(e);
        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        waited = 0;
        while ((sb.size() != 0 || busy[u]) && waited < 400) begin
            @(negedge clk);
            waited++;
            start[u] = (mid_start != 0 && waited == mid_start);
        end
        start[u] = 1'b0;
        if (waited >= 400) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout unit=%0d target=%0h actual=busy expected=done", u, tgt);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int dc;
        ovr       = 1'b0;
        start[0]  = 1'b0;
        start[1]  = 1'b0;
        target[0] = 8'h00;
        target[1] = 8'h00;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_unit0", {44'd0, probe[0], result[0], done[0], busy[0], found[0], err[0]}, 64'd0);
        checkOutput("reset_unit1", {44'd0, probe[1], result[1], done[1], busy[1], found[1], err[1]}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(0, 8'h5A, 8'h5A, 1'b1, 1'b0, 7, 64'h80406050585C5A00, 7, 0);
        applyStimulus(0, 8'h00, 8'h00, 1'b0, 1'b0, 8, 64'h8040201008040201, 8, 0);
        applyStimulus(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8, 64'h80C0E0F0F8FCFEFF, 8, 0);
        applyStimulus(0, 8'h80, 8'h80, 1'b1, 1'b0, 1, 64'h8000000000000000, 1, 0);
        applyStimulus(0, 8'h01, 8'h01, 1'b1, 1'b0, 8, 64'h8040201008040201, 8, 0);
        applyStimulus(1, 8'h00, 8'h00, 1'b0, 1'b0, 8, 64'h8040201008040201, 24, 10);
        applyStimulus(1, 8'hA5, 8'hA5, 1'b1, 1'b0, 8, 64'h80C0A0B0A8A4A6A5, 24, 0);

        ovr = 1'b1;
        applyStimulus(0, 8'h33, 8'h00, 1'b0, 1'b1, 1, 64'h8000000000000000, 1, 0);
        ovr = 1'b0;

        // Abort a 0x5A search just before its fourth decision.
        target[0] = 8'h5A;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_abort_probe", 64'(probe[0]), 64'h50);
        dc  = done_count[0];
        rst = 1'b1;
        #1;
        checkOutput("abort_outputs", {44'd0, probe[0], result[0], done[0], busy[0], found[0], err[0]}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("no_done_after_abort", 64'(done_count[0]), 64'(dc));
        applyStimulus(0, 8'h5A, 8'h5A, 1'b1, 1'b0, 7, 64'h80406050585C5A00, 7, 0);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
